// File: rtl/divisor_pkg.sv
// Shared types and helpers for the parametrised sequential divider.
package divisor_pkg;

    typedef enum logic [1:0] {
        IDLE,
        OPERA,
        CORRIGE
    } estado_t;

    // Counter must hold the value tamanyo itself, hence tamanyo+1 codes.
    function automatic int ancho_cont(input int tamanyo);
        return $clog2(tamanyo + 1);
    endfunction

endpackage

// File: rtl/divisor_paso.sv
// One combinational restoring-division step: shift in the next dividend bit
// and subtract the divisor when the shifted remainder is large enough.
module divisor_paso #(
    parameter int tamanyo = 32
) (
    input  logic [tamanyo:0]   resto,
    input  logic               bit_msb,
    input  logic [tamanyo-1:0] divisor,
    output logic [tamanyo:0]   nuevo_resto,
    output logic               bit_coc
);

    logic [tamanyo+1:0] desplazado;
    logic [tamanyo+1:0] divisor_ext;

    // Compare/subtract on a widened copy so no bit of the shifted value is lost.
    always_comb begin
        desplazado  = {resto, bit_msb};
        divisor_ext = {2'b00, divisor};
        if (desplazado >= divisor_ext) begin
            bit_coc     = 1'b1;
            nuevo_resto = (tamanyo+1)'(desplazado - divisor_ext);
        end else begin
            bit_coc     = 1'b0;
            nuevo_resto = desplazado[tamanyo:0];
        end
    end

endmodule

// File: rtl/divisor_parametrico.sv
// Parametrised radix-2 restoring divider, signed/unsigned per operation,
// with ready, divide-by-zero and signed-overflow indications.
module divisor_parametrico
    import divisor_pkg::*;
#(
    parameter int tamanyo = 32
) (
    input  logic               CLK,
    input  logic               RSTn,
    input  logic               START,
    input  logic               SIGNO,
    input  logic [tamanyo-1:0] NUM,
    input  logic [tamanyo-1:0] DEN,
    output logic               RDY,
    output logic [tamanyo-1:0] COC,
    output logic [tamanyo-1:0] RES,
    output logic               DONE,
    output logic               DZ,
    output logic               OVF
);

    localparam int              CW     = ancho_cont(tamanyo);
    localparam logic [CW-1:0]   CARGA  = CW'(tamanyo);
    localparam logic [tamanyo-1:0] MINIMO = {1'b1, {(tamanyo-1){1'b0}}};

    estado_t            estado;
    logic [tamanyo:0]   resto;
    logic [tamanyo-1:0] dividendo;
    logic [tamanyo-1:0] divisor;
    logic [CW-1:0]      cont;
    logic               neg_coc;
    logic               neg_res;
    logic               dz_pend;
    logic               ovf_pend;

    logic [tamanyo-1:0] mag_num;
    logic [tamanyo-1:0] mag_den;
    logic [tamanyo:0]   nuevo_resto;
    logic               bit_coc;

    // Operand magnitudes; only signed mode takes the absolute value.
    always_comb begin
        mag_num = (SIGNO && NUM[tamanyo-1]) ? -NUM : NUM;
        mag_den = (SIGNO && DEN[tamanyo-1]) ? -DEN : DEN;
    end

    divisor_paso #(
        .tamanyo(tamanyo)
    ) u_paso (
        .resto      (resto),
        .bit_msb    (dividendo[tamanyo-1]),
        .divisor    (divisor),
        .nuevo_resto(nuevo_resto),
        .bit_coc    (bit_coc)
    );

    // Control FSM with registered outputs; dividendo shifts out dividend bits
    // and shifts in quotient bits, so it ends up holding the quotient.
    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            estado    <= IDLE;
            RDY       <= 1'b1;
            COC       <= '0;
            RES       <= '0;
            DONE      <= 1'b0;
            DZ        <= 1'b0;
            OVF       <= 1'b0;
            resto     <= '0;
            dividendo <= '0;
            divisor   <= '0;
            cont      <= '0;
            neg_coc   <= 1'b0;
            neg_res   <= 1'b0;
            dz_pend   <= 1'b0;
            ovf_pend  <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (estado)
                IDLE: begin
                    if (START) begin
                        RDY <= 1'b0;
                        if (DEN == '0) begin
                            dz_pend   <= 1'b1;
                            ovf_pend  <= 1'b0;
                            dividendo <= NUM;
                            estado    <= CORRIGE;
                        end else begin
                            dz_pend   <= 1'b0;
                            ovf_pend  <= SIGNO && (NUM == MINIMO) && (DEN == '1);
                            neg_coc   <= SIGNO && (NUM[tamanyo-1] ^ DEN[tamanyo-1]);
                            neg_res   <= SIGNO && NUM[tamanyo-1];
                            dividendo <= mag_num;
                            divisor   <= mag_den;
                            resto     <= '0;
                            cont      <= CARGA;
                            estado    <= OPERA;
                        end
                    end
                end
                OPERA: begin
                    resto     <= nuevo_resto;
                    dividendo <= {dividendo[tamanyo-2:0], bit_coc};
                    cont      <= cont - 1'b1;
                    if (cont == CW'(1)) begin
                        estado <= CORRIGE;
                    end
                end
                CORRIGE: begin
                    if (dz_pend) begin
                        COC <= '1;
                        RES <= dividendo;
                        DZ  <= 1'b1;
                        OVF <= 1'b0;
                    end else begin
                        COC <= neg_coc ? -dividendo : dividendo;
                        RES <= neg_res ? -resto[tamanyo-1:0] : resto[tamanyo-1:0];
                        DZ  <= 1'b0;
                        OVF <= ovf_pend;
                    end
                    DONE   <= 1'b1;
                    RDY    <= 1'b1;
                    estado <= IDLE;
                end
                default: begin
                    RDY    <= 1'b1;
                    estado <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/divisor_parametrico.md
# divisor_parametrico

Parametrised sequential integer divider that replaces the fixed unsigned algorithmic divider in the arithmetic datapath.
- Computes quotient and remainder one bit per clock, restoring radix-2.
- Adds a per-operation signed/unsigned mode, a ready indication, divide-by-zero detection and signed-overflow detection.
- Sits behind the same START/DONE command interface, so existing drivers reuse their reset/divide task sequences unchanged.

## Interface
- tamanyo, 32, operand/result width in bits (≥ 2)
- CLK  in  1  system clock, all logic on rising edge
- RSTn  in  1  reset, synchronous, active-low
- START  in  1  request; sampled only while RDY=1
- SIGNO  in  1  mode, sampled with START: 0 unsigned, 1 two's-complement signed
- NUM  in  tamanyo  dividend, sampled with START
- DEN  in  tamanyo  divisor, sampled with START
- RDY  out  1  high in IDLE (accepting START)
- COC  out  tamanyo  quotient
- RES  out  tamanyo  remainder
- DONE  out  1  one-cycle pulse, COC/RES/DZ/OVF valid
- DZ  out  1  divide-by-zero flag for the last operation
- OVF  out  1  signed overflow flag (min / −1) for the last operation

## Operation
- States: IDLE, OPERA, CORRIGE.
- IDLE:
  - RDY=1.
  - On START=1 with DEN≠0: latch SIGNO; latch |NUM| and |DEN| (magnitude only when SIGNO=1); latch the sign of the result and of the dividend; clear the partial remainder; load the counter with tamanyo; go to OPERA.
  - On START=1 with DEN=0: go directly to CORRIGE with DZ pending.
- OPERA: one restoring step per cycle.
  - Shift {resto, dividendo} left by 1.
  - If resto ≥ divisor, subtract and set the quotient LSB to 1.
  - Decrement the counter. At 1, go to CORRIGE.
- CORRIGE:
  - Register COC/RES, applying sign correction in signed mode.
  - Quotient is negated if the operand signs differ (truncation toward zero).
  - Remainder takes the dividend's sign.
  - Set DONE=1 for this one cycle, then go to IDLE.
- Divide by zero: COC = all ones, RES = NUM (raw), DZ=1, OVF=0, in both modes.
- Signed overflow: SIGNO=1, NUM = 2^(tamanyo−1), DEN = all ones → COC = 2^(tamanyo−1) (wrapped), RES=0, OVF=1.
- Internal width: the partial remainder is tamanyo+1 bits, so magnitude 2^(tamanyo−1) needs no special case.
- START while RDY=0 is ignored; it is neither queued nor able to corrupt the operation in flight.
- COC, RES, DZ and OVF hold their values from DONE until the next DONE.

## Timing
- Reset values (RSTn=0 at a rising edge): state IDLE, RDY=1, COC=0, RES=0, DONE=0, DZ=0, OVF=0, counter 0.
- Reset mid-operation: aborts to IDLE on that edge, outputs zeroed, no DONE.
- Normal latency: START sampled at edge k → DONE high between edges k+tamanyo+1 and k+tamanyo+2. That is 33 cycles for tamanyo=32.
- Divide-by-zero latency: DONE high between edges k+1 and k+2.
- RDY drops the cycle after the accepting edge and returns the same cycle DONE is high. START held high through DONE is therefore accepted on the edge that ends the DONE cycle (back-to-back, no idle cycle).
- DONE is never high for two consecutive cycles.

## Structure
- Package divisor_pkg holds:
  - typedef enum logic [1:0] estado_t {IDLE, OPERA, CORRIGE}
  - function for the counter width, $clog2(tamanyo+1)
- Sub-module divisor_paso: combinational single restoring step.
  - Inputs: partial remainder (tamanyo+1 bits), dividend MSB, divisor.
  - Outputs: new remainder, quotient bit.
  - Instantiated once inside the FSM.

## Test plan
- tamanyo=32, SIGNO=0, NUM=4, DEN=2 → DONE 33 cycles after START, COC=2, RES=0, DZ=0, OVF=0.
- SIGNO=1, NUM=−7, DEN=2 → COC=−3 (0xFFFFFFFD), RES=−1; then NUM=7, DEN=−2 → COC=−3, RES=1.
- NUM=7, DEN=0 (both modes) → DONE after 1 cycle, DZ=1, COC=0xFFFFFFFF, RES=7.
- SIGNO=1, NUM=0x80000000, DEN=0xFFFFFFFF → OVF=1, COC=0x80000000, RES=0; same operands with SIGNO=0 → COC=0, RES=0x80000000, OVF=0.
- START pulsed mid-operation → ignored, result unchanged; RSTn=0 for one edge at cycle 10 of an operation → IDLE, outputs 0, no DONE.
- tamanyo=8, SIGNO=0, NUM=255, DEN=16 → COC=15, RES=15 after 9 cycles; START held high → second operation accepted back-to-back.
